// File: rtl/sn74_demux_latch.sv
// Reassembles {B, A} words from a nibble-multiplexed bus into a one-deep output register.
// A completed pair that cannot be loaded is dropped, and the sticky ovf flag is set.
module sn74_demux_latch #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   y,
   input  logic               sel,
   input  logic               stb_n,
   output logic [2*WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               ovf,
   input  logic               ovf_clr,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HAVE_A = 2'd1,
      HAVE_B = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] word;
   logic               sample, pair, loadable, consume;

   assign sample   = ~stb_n;
   assign loadable = ~out_valid | out_ready;
   assign consume  = out_valid & out_ready;
   assign state    = state_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      pair    = 1'b0;
      word    = {b_q, a_q};
      case (state_q)
         EMPTY: if (sample) begin
            if (sel) begin
               b_d     = y;
               state_d = HAVE_B;
            end else begin
               a_d     = y;
               state_d = HAVE_A;
            end
         end
         HAVE_A: if (sample) begin
            if (sel) begin
               // completing half bypasses the register so the word is ready this edge
               pair    = 1'b1;
               word    = {y, a_q};
               state_d = EMPTY;
            end else begin
               a_d = y;
            end
         end
         HAVE_B: if (sample) begin
            if (!sel) begin
               pair    = 1'b1;
               word    = {b_q, y};
               state_d = EMPTY;
            end else begin
               b_d = y;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (pair && loadable) begin
         out_data  <= word;
         out_valid <= 1'b1;
      end else if (consume) begin
         out_valid <= 1'b0;
      end
   end

   // a same-edge overflow takes priority over the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    ovf <= 1'b0;
      else if (pair && !loadable) ovf <= 1'b1;
      else if (ovf_clr)           ovf <= 1'b0;
   end

endmodule

// File: tb/tb_sn74_demux_latch.sv
// Directed bench for sn74_demux_latch: pairing, overflow, back-to-back load, async reset, idle hold.
module tb_sn74_demux_latch;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] y;
   logic       sel;
   logic       stb_n;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       ovf;
   logic       ovf_clr;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   sn74_demux_latch #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .y(y), .sel(sel), .stb_n(stb_n),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ovf(ovf), .ovf_clr(ovf_clr), .state(state)
   );

   always #5 clk = ~clk;

   task automatic sample(input logic s, input logic [3:0] d);
      @(negedge clk);
      stb_n = 1'b0;
      sel   = s;
      y     = d;
      @(posedge clk);
      #1;
      stb_n = 1'b1;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; y = '0; sel = 1'b0; stb_n = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_data, out_valid, ovf, state} !== 12'h000) begin
         errors++;
         $display("FAIL reset: got data=%h v=%b ovf=%b st=%0d want 0", out_data, out_valid, ovf, state);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      sample(1'b0, 4'h3);
      checks++;
      if (out_valid !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL basic_half: got v=%b st=%0d want v=0 st=1", out_valid, state);
      end
      sample(1'b1, 4'hA);
      checks++;
      if (out_data !== 8'hA3 || out_valid !== 1'b1 || state !== 2'd0) begin
         errors++;
         $display("FAIL basic_pair: got data=%h v=%b st=%0d want A3 1 0", out_data, out_valid, state);
      end
      idle_cycle();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'hA3) begin
         errors++;
         $display("FAIL basic_consume: got data=%h v=%b want A3 0", out_data, out_valid);
      end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      sample(1'b1, 4'h5);
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL ovf_have_b: got st=%0d want 2", state);
      end
      sample(1'b0, 4'h6);
      checks++;
      if (out_data !== 8'h56 || out_valid !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_first: got data=%h v=%b ovf=%b want 56 1 0", out_data, out_valid, ovf);
      end
      sample(1'b0, 4'h1);
      sample(1'b1, 4'h2);
      checks++;
      if (ovf !== 1'b1 || out_data !== 8'h56 || out_valid !== 1'b1 || state !== 2'd0) begin
         errors++;
         $display("FAIL ovf_drop: got data=%h v=%b ovf=%b st=%0d want 56 1 1 0", out_data, out_valid, ovf, state);
      end
      idle_cycle();
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b want 1", ovf);
      end
      ovf_clr = 1'b1;
      idle_cycle();
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clr: got ovf=%b v=%b want 0 1", ovf, out_valid);
      end
      out_ready = 1'b1;
      idle_cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drain: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_overwrite();
      out_ready = 1'b1;
      sample(1'b0, 4'h4);
      sample(1'b0, 4'h7);
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL overwrite_state: got st=%0d want 1", state);
      end
      sample(1'b1, 4'h9);
      checks++;
      if (out_data !== 8'h97 || out_valid !== 1'b1 || state !== 2'd0) begin
         errors++;
         $display("FAIL overwrite_pair: got data=%h v=%b st=%0d want 97 1 0", out_data, out_valid, state);
      end
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      sample(1'b0, 4'h1);
      sample(1'b1, 4'h2);
      checks++;
      if (out_data !== 8'h21 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got data=%h v=%b want 21 1", out_data, out_valid);
      end
      sample(1'b0, 4'h3);
      out_ready = 1'b1;
      sample(1'b1, 4'h4);
      checks++;
      if (out_data !== 8'h43 || out_valid !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_swap: got data=%h v=%b ovf=%b want 43 1 0", out_data, out_valid, ovf);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      sample(1'b0, 4'hF);
      checks++;
      if (state !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'h43) begin
         errors++;
         $display("FAIL arst_pre: got data=%h v=%b st=%0d want 43 1 1", out_data, out_valid, state);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_data, out_valid, ovf, state} !== 12'h000) begin
         errors++;
         $display("FAIL arst_async: got data=%h v=%b ovf=%b st=%0d want 0", out_data, out_valid, ovf, state);
      end
      // a strobe while reset is held must be ignored
      @(negedge clk);
      stb_n = 1'b0; sel = 1'b0; y = 4'h5; out_ready = 1'b1;
      @(posedge clk);
      #1;
      stb_n = 1'b1;
      checks++;
      if (state !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL arst_hold: got st=%0d v=%b want 0 0", state, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      sample(1'b1, 4'h2);
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL arst_resume: got st=%0d want 2", state);
      end
      sample(1'b0, 4'h3);
      checks++;
      if (out_data !== 8'h23 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_pair: got data=%h v=%b want 23 1", out_data, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_idle();
      sample(1'b0, 4'h8);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         sel = i[0];
         y   = 4'(i * 3);
         @(posedge clk);
         #1;
         checks++;
         if (state !== 2'd1 || out_valid !== 1'b1 || ovf !== 1'b0 || out_data !== 8'h23) begin
            errors++;
            $display("FAIL idle_%0d: got data=%h v=%b ovf=%b st=%0d want 23 1 0 1", i, out_data, out_valid, ovf, state);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_overwrite();
      test_back_to_back();
      test_async_reset();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sn74_demux_latch.md
SN74_DEMUX_LATCH -- requirements
Module: sn74_demux_latch

Interface
REQ-001 Parameter: WIDTH, default 4, width of one half (nibble) of the multiplexed bus.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: y  input  WIDTH  multiplexed data bus (driven by a '157-style selector).
REQ-005 Port: sel  input  1  half select: 0 = half A, 1 = half B (nA_B sense).
REQ-006 Port: stb_n  input  1  active-low strobe; y/sel sampled on every rising clk edge while low.
REQ-007 Port: out_data  output  2*WIDTH  reassembled word {B, A}.
REQ-008 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-009 Port: out_ready  input  1  consumer accepts word when out_valid and out_ready are both high at a clk edge.
REQ-010 Port: ovf  output  1  sticky overflow flag.
REQ-011 Port: ovf_clr  input  1  synchronous clear of ovf.
REQ-012 Port: state  output  2  current FSM state code (debug).

Function
REQ-013 All inputs synchronous to clk; no input synchronizers inside the block.
REQ-014 FSM states: EMPTY (code 0), HAVE_A (code 1), HAVE_B (code 2); code 3 unused, decodes to EMPTY next cycle.
REQ-015 Sample = stb_n low at edge; no sample -> FSM and half registers hold.
REQ-016 EMPTY: sample sel=0 -> store y in a_q, go HAVE_A; sel=1 -> store y in b_q, go HAVE_B.
REQ-017 HAVE_A: sample sel=0 -> overwrite a_q, stay; sel=1 -> pair complete with b=y, go EMPTY.
REQ-018 HAVE_B: sample sel=1 -> overwrite b_q, stay; sel=0 -> pair complete with a=y, go EMPTY.
REQ-019 Pair-complete word = {B half, A half}, using the current y for the completing half (no extra cycle).
REQ-020 Output register one entry deep; loadable when out_valid low, or out_valid and out_ready high same edge.
REQ-021 Pair complete and loadable -> out_data = word, out_valid = 1 after that edge; latency 1 clk from completing sample.
REQ-022 Pair complete and not loadable -> word dropped, out_data unchanged, ovf set, FSM still to EMPTY.
REQ-023 Consume (out_valid & out_ready) without simultaneous load -> out_valid = 0 next cycle; out_data holds last value.
REQ-024 Simultaneous consume and load -> out_valid stays 1, out_data takes new word, no overflow.
REQ-025 ovf_clr high clears ovf unless an overflow occurs same edge; set wins.
REQ-026 out_data, out_valid change only per REQ-021..024; out_ready ignored while out_valid low.

Reset
REQ-027 rst high immediately forces state=EMPTY, a_q=0, b_q=0, out_data=0, out_valid=0, ovf=0, regardless of clk.
REQ-028 Reset mid-pair discards stored half; first post-reset sample treated as from EMPTY.
REQ-029 While rst high, samples and out_ready ignored; operation resumes on first clk edge after rst low.

Verification
REQ-030 Bench: reset, out_ready=1; sample (sel=0,y=3) then (sel=1,y=A) -> out_data=0xA3, out_valid=1 one cycle after second sample, then 0.
REQ-031 Bench: out_ready=0; sample (1,5),(0,6) -> 0x56 valid; then (0,1),(1,2) -> ovf=1, out_data stays 0x56; ovf_clr pulse -> ovf=0.
REQ-032 Bench: sample (0,4),(0,7),(1,9) -> out_data=0x97 (A overwritten), state back to EMPTY (0).
REQ-033 Bench: out_valid=1 with 0x21, complete pair 0x43 while out_ready=1 same edge -> out_valid stays 1, out_data=0x43, ovf=0.
REQ-034 Bench: sample (0,F), assert rst between clk edges -> outputs zero immediately; then (1,2),(0,3) -> out_data=0x23.
REQ-035 Bench: stb_n high for 10 cycles with y/sel toggling -> state, out_valid, ovf unchanged.
